// File: rtl/ann_sample_sequencer_pkg.sv
// Shared types and default dimensions for the ANN sample sequencer.
// Holds the FSM state enum and the packed vector types used on the network side.
package ann_seq_pkg;

  localparam int ANN_N_IN    = 4;
  localparam int ANN_N_OUT   = 2;
  localparam int ANN_DW      = 16;
  localparam int ANN_DEPTH   = 16;
  localparam int ANN_TIMEOUT = 4096;

  typedef logic [ANN_N_IN*ANN_DW-1:0]  in_vec_t;
  typedef logic [ANN_N_OUT*ANN_DW-1:0] out_vec_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESENT = 3'd1,
    LAUNCH  = 3'd2,
    WAIT    = 3'd3,
    NEXT    = 3'd4,
    FINISH  = 3'd5
  } state_t;

  // A programmed epoch count of zero still runs the set once.
  function automatic logic [7:0] eff_epochs(input logic [7:0] n);
    return (n == 8'd0) ? 8'd1 : n;
  endfunction

endpackage

// File: rtl/ann_sample_sequencer_if.sv
// Bundle of load, control, network and result signals for the sample sequencer.
// The slave modport is the sequencer side; master is the surrounding system.
interface ann_sample_sequencer_if
  import ann_seq_pkg::*;
#(
  parameter int N_IN  = ANN_N_IN,
  parameter int N_OUT = ANN_N_OUT,
  parameter int DW    = ANN_DW,
  parameter int DEPTH = ANN_DEPTH
) ();

  localparam int IW = $clog2(DEPTH);

  // Load handshake: a sample transfers on any rising edge where ld_valid and
  // ld_ready are both high; ld_ready never depends on ld_valid.
  logic                  ld_valid;
  logic                  ld_ready;
  logic [N_IN*DW-1:0]    ld_input;
  logic [N_OUT*DW-1:0]   ld_desired;
  logic                  clear;
  logic                  start;
  logic                  train_mode;
  logic [7:0]            num_epochs;
  logic [N_IN*DW-1:0]    ann_input;
  logic [N_OUT*DW-1:0]   ann_desired;
  logic                  ann_train;
  logic                  ann_done;
  logic                  ann_valid;
  logic [N_OUT*DW-1:0]   ann_test_output;
  logic                  res_valid;
  logic [N_OUT*DW-1:0]   res_data;
  logic [IW-1:0]         res_index;
  logic                  busy;
  logic                  run_done;
  logic                  timeout_err;
  logic [IW:0]           count;
  state_t                dbg_state;

  modport slave (
    input  ld_valid, ld_input, ld_desired, clear, start, train_mode, num_epochs,
    input  ann_valid, ann_test_output,
    output ld_ready, ann_input, ann_desired, ann_train, ann_done,
    output res_valid, res_data, res_index, busy, run_done, timeout_err, count,
    output dbg_state
  );

  modport master (
    output ld_valid, ld_input, ld_desired, clear, start, train_mode, num_epochs,
    output ann_valid, ann_test_output,
    input  ld_ready, ann_input, ann_desired, ann_train, ann_done,
    input  res_valid, res_data, res_index, busy, run_done, timeout_err, count,
    input  dbg_state
  );

endinterface

// File: rtl/ann_sample_sequencer_sample_buffer.sv
// Sample storage: one write port, one registered read port.
// The read register is cleared by reset so the network sees zeros before the first run.
module sample_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (!RST) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ann_sample_sequencer.sv
// Replays a buffered set of training samples to the ANN for a number of epochs,
// launching one network pass per sample and streaming inference results out.
module ann_sample_sequencer
  import ann_seq_pkg::*;
#(
  parameter int N_IN    = ANN_N_IN,
  parameter int N_OUT   = ANN_N_OUT,
  parameter int DW      = ANN_DW,
  parameter int DEPTH   = ANN_DEPTH,
  parameter int TIMEOUT = ANN_TIMEOUT
) (
  input  logic                  CLK,
  input  logic                  RST,
  ann_sample_sequencer_if.slave bus
);

  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = IW + 1;
  localparam int TW  = $clog2(TIMEOUT);
  localparam int IVW = N_IN * DW;
  localparam int OVW = N_OUT * DW;
  localparam int WW  = IVW + OVW;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      epoch_q, epoch_d;
  logic [7:0]      epochs_q, epochs_d;
  logic            mode_q, mode_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            terr_q, terr_d;
  logic            res_valid_q, res_valid_d;
  logic [OVW-1:0]  res_data_q, res_data_d;
  logic [IW-1:0]   res_index_q, res_index_d;
  logic            empty_done_q, empty_done_d;

  logic            ld_ready;
  logic            buf_we;
  logic            buf_re;
  logic [WW-1:0]   buf_rdata;

  assign ld_ready = (state_q == IDLE) && (count_q < CW'(DEPTH));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    epoch_d      = epoch_q;
    epochs_d     = epochs_q;
    mode_d       = mode_q;
    tmo_d        = tmo_q;
    terr_d       = terr_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_index_d  = res_index_q;
    empty_done_d = 1'b0;
    buf_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          count_d = '0;
        end else if (bus.ld_valid && ld_ready) begin
          buf_we  = 1'b1;
          count_d = count_q + 1'b1;
        end
        // A same-cycle clear empties the set, so it also suppresses start.
        if (bus.start && !bus.clear) begin
          if (count_q == '0) begin
            empty_done_d = 1'b1;
          end else begin
            mode_d   = bus.train_mode;
            epochs_d = eff_epochs(bus.num_epochs);
            idx_d    = '0;
            epoch_d  = '0;
            terr_d   = 1'b0;
            state_d  = PRESENT;
          end
        end
      end
      PRESENT: state_d = LAUNCH;
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.ann_valid) begin
          if (!mode_q) begin
            res_valid_d = 1'b1;
            res_data_d  = bus.ann_test_output;
            res_index_d = idx_q;
          end
          state_d = NEXT;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = FINISH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      NEXT: begin
        if (idx_q == IW'(count_q - 1'b1)) begin
          idx_d = '0;
          if ((epoch_q + 8'd1) == epochs_q) begin
            state_d = FINISH;
          end else begin
            epoch_d = epoch_q + 8'd1;
            state_d = PRESENT;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = PRESENT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read one edge early so the sample is on ann_input during PRESENT.
    buf_re = (state_d == PRESENT);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      epoch_q      <= '0;
      epochs_q     <= 8'd1;
      mode_q       <= 1'b0;
      tmo_q        <= '0;
      terr_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_index_q  <= '0;
      empty_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      epoch_q      <= epoch_d;
      epochs_q     <= epochs_d;
      mode_q       <= mode_d;
      tmo_q        <= tmo_d;
      terr_q       <= terr_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_index_q  <= res_index_d;
      empty_done_q <= empty_done_d;
    end
  end

  sample_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_buf (
    .CLK   (CLK),
    .RST   (RST),
    .we    (buf_we),
    .waddr (count_q[IW-1:0]),
    .wdata ({bus.ld_input, bus.ld_desired}),
    .re    (buf_re),
    .raddr (idx_d),
    .rdata (buf_rdata)
  );

  assign bus.ld_ready    = ld_ready;
  assign bus.busy        = (state_q != IDLE);
  assign bus.ann_input   = buf_rdata[WW-1 -: IVW];
  assign bus.ann_desired = buf_rdata[OVW-1:0];
  assign bus.ann_done    = (state_q == LAUNCH);
  assign bus.ann_train   = mode_q && (state_q inside {PRESENT, LAUNCH, WAIT, NEXT});
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_index   = res_index_q;
  assign bus.run_done    = empty_done_q || (state_q == FINISH);
  assign bus.timeout_err = terr_q;
  assign bus.count       = count_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_ann_sample_sequencer.sv
// Scoreboard bench for ann_sample_sequencer: a reference model of the sample set
// predicts every launch and inference result; monitors compare as the DUT presents them.
module tb_ann_sample_sequencer;
  import ann_seq_pkg::*;

  localparam int N_IN    = ANN_N_IN;
  localparam int N_OUT   = ANN_N_OUT;
  localparam int DW      = ANN_DW;
  localparam int DEPTH   = ANN_DEPTH;
  localparam int TIMEOUT = ANN_TIMEOUT;
  localparam int IW      = $clog2(DEPTH);
  localparam int IVW     = N_IN * DW;
  localparam int OVW     = N_OUT * DW;
  localparam int LW      = IVW + OVW + 1;
  localparam int RW      = IW + OVW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ann_sample_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .DEPTH(DEPTH)) bus ();

  ann_sample_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [LW-1:0]  exp_q[$];
  logic [RW-1:0]  res_exp_q[$];
  logic [OVW-1:0] net_resp_q[$];
  in_vec_t        m_in[DEPTH];
  out_vec_t       m_des[DEPTH];
  int             m_count   = 0;
  bit             net_on    = 1'b1;
  int             net_lat   = 5;
  int             launches  = 0;
  int             results   = 0;
  int             run_dones = 0;
  int             last_done = -1;
  int             n_checks  = 0;
  int             n_fail    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ann_done) begin
        launches++;
        check("launch_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0)
          check("launch_payload", {bus.ann_input, bus.ann_desired, bus.ann_train}, exp_q.pop_front());
        if (net_on && last_done >= 0)
          check("valid_to_done_gap", cyc - last_done, net_lat + 3);
        last_done = cyc;
      end
      if (bus.res_valid) begin
        results++;
        check("res_expected", res_exp_q.size() > 0, 1);
        if (res_exp_q.size() > 0)
          check("res_payload", {bus.res_index, bus.res_data}, res_exp_q.pop_front());
      end
      if (bus.run_done) run_dones++;
    end
  end

  // ---------------- network model ----------------
  initial begin
    bus.ann_valid       = 1'b0;
    bus.ann_test_output = '0;
    forever begin
      @(negedge clk);
      if (bus.ann_done && net_on) begin
        repeat (net_lat) @(negedge clk);
        bus.ann_valid       = 1'b1;
        bus.ann_test_output = (net_resp_q.size() > 0) ? net_resp_q.pop_front() : '0;
        @(negedge clk);
        bus.ann_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input in_vec_t vin, input out_vec_t vdes);
    bus.ld_valid   = 1'b1;
    bus.ld_input   = vin;
    bus.ld_desired = vdes;
    check("ld_ready", bus.ld_ready, m_count < DEPTH);
    if (m_count < DEPTH) begin
      m_in[m_count]  = vin;
      m_des[m_count] = vdes;
      m_count++;
    end
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) load({$urandom(), $urandom()}, $urandom());
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    m_count = 0;
  endtask

  task automatic start_run(input bit mode, input logic [7:0] ne);
    int eff;
    int k;
    logic [OVW-1:0] r;
    eff = (ne == 8'd0) ? 1 : int'(ne);
    k = 0;
    last_done = -1;
    for (int e = 0; e < eff; e++) begin
      for (int i = 0; i < m_count; i++) begin
        exp_q.push_back({m_in[i], m_des[i], mode});
        if (!mode && net_on) begin
          if (k >= net_resp_q.size()) begin
            r = OVW'($urandom());
            net_resp_q.push_back(r);
          end
          res_exp_q.push_back({IW'(i), net_resp_q[k]});
          k++;
        end
      end
    end
    bus.start      = 1'b1;
    bus.train_mode = mode;
    bus.num_epochs = ne;
    tick();
    bus.start      = 1'b0;
    bus.train_mode = 1'($urandom());
    bus.num_epochs = 8'($urandom());
    check("busy_after_start", bus.busy, 1);
    check("timeout_err_cleared", bus.timeout_err, 0);
    check("done_not_early", bus.ann_done, 0);
    tick();
    check("start_to_done_2cyc", bus.ann_done, 1);
    check("ann_train_latched", bus.ann_train, mode);
  endtask

  task automatic wait_done(input int budget, output int waited);
    int rd0;
    rd0 = run_dones;
    waited = 0;
    while (!bus.run_done && waited < budget) begin
      tick();
      waited++;
    end
    check("run_done_within_budget", bus.run_done, 1);
    tick(2);
    check("run_done_once", run_dones - rd0, 1);
    check("idle_after_run", bus.dbg_state, IDLE);
    check("not_busy_after_run", bus.busy, 0);
    check("launch_q_drained", exp_q.size(), 0);
    check("res_q_drained", res_exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int l0;
    int r0;
    bus.ld_valid   = 1'b0;
    bus.ld_input   = '0;
    bus.ld_desired = '0;
    bus.clear      = 1'b0;
    bus.start      = 1'b0;
    bus.train_mode = 1'b0;
    bus.num_epochs = 8'd0;
    tick(3);
    check("rst_state", bus.dbg_state, IDLE);
    check("rst_count", bus.count, 0);
    check("rst_ld_ready", bus.ld_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_ann_done", bus.ann_done, 0);
    check("rst_ann_train", bus.ann_train, 0);
    check("rst_ann_input", bus.ann_input, 0);
    check("rst_ann_desired", bus.ann_desired, 0);
    check("rst_res", {bus.res_valid, bus.res_index, bus.res_data}, 0);
    check("rst_run_done", bus.run_done, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // 1: training, 3 samples, 2 epochs
    load_random(3);
    net_on = 1'b1; net_lat = 5;
    l0 = launches; r0 = results;
    start_run(1'b1, 8'd2);
    wait_done(300, w);
    check("t1_launches", launches - l0, 6);
    check("t1_no_results", results - r0, 0);

    // 2: inference, 2 samples, epochs=0 behaves as 1
    do_clear();
    load_random(2);
    net_resp_q.push_back(32'h0011_0022);
    net_resp_q.push_back(32'h0033_0044);
    l0 = launches; r0 = results;
    start_run(1'b0, 8'd0);
    wait_done(200, w);
    check("t2_launches", launches - l0, 2);
    check("t2_results", results - r0, 2);

    // 3: fill, refuse 17th, replay to confirm contents, then clear
    do_clear();
    load_random(DEPTH);
    check("full_count", bus.count, DEPTH);
    bus.ld_valid = 1'b1;
    bus.ld_input = {$urandom(), $urandom()};
    bus.ld_desired = $urandom();
    check("full_ld_ready", bus.ld_ready, 0);
    tick(2);
    bus.ld_valid = 1'b0;
    check("full_count_held", bus.count, DEPTH);
    net_lat = 1;
    start_run(1'b1, 8'd1);
    wait_done(400, w);
    do_clear();
    check("clear_count", bus.count, 0);
    check("clear_ld_ready", bus.ld_ready, 1);
    bus.clear = 1'b1;
    bus.ld_valid = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.ld_valid = 1'b0;
    check("clear_beats_load", bus.count, 0);

    // 4: network never answers
    load_random(1);
    net_on = 1'b0;
    start_run(1'b1, 8'd1);
    wait_done(TIMEOUT + 200, w);
    check("timeout_wait_cycles", w, TIMEOUT + 1);
    check("timeout_err_set", bus.timeout_err, 1);
    net_on = 1'b1; net_lat = 2;
    start_run(1'b1, 8'd1);
    wait_done(100, w);
    check("timeout_err_stays_clear", bus.timeout_err, 0);

    // 5: reset while waiting on the network
    do_clear();
    load_random(2);
    net_on = 1'b0;
    start_run(1'b1, 8'd1);
    tick(10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    res_exp_q.delete();
    m_count = 0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_ann_done", bus.ann_done, 0);
    check("midrst_count", bus.count, 0);
    check("midrst_ann_train", bus.ann_train, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("empty_start_run_done", bus.run_done, 1);
    check("empty_start_not_busy", bus.busy, 0);
    tick();
    check("empty_start_pulse_ends", bus.run_done, 0);

    // 6: start and load offered while busy
    net_on = 1'b1; net_lat = 3;
    load_random(3);
    l0 = launches;
    start_run(1'b1, 8'd1);
    for (int i = 0; i < 6; i++) begin
      bus.start = 1'b1;
      bus.ld_valid = 1'b1;
      bus.ld_input = {$urandom(), $urandom()};
      bus.ld_desired = $urandom();
      tick();
    end
    bus.start = 1'b0;
    bus.ld_valid = 1'b0;
    wait_done(200, w);
    check("busy_ignores_load", bus.count, 3);
    check("busy_ignores_start", launches - l0, 3);

    // random runs
    for (int r = 0; r < 5; r++) begin
      int n;
      int ne;
      bit md;
      do_clear();
      n  = $urandom_range(1, 5);
      ne = $urandom_range(0, 3);
      md = 1'($urandom());
      net_lat = $urandom_range(1, 6);
      load_random(n);
      l0 = launches;
      start_run(md, 8'(ne));
      wait_done(600, w);
      check("rand_launches", launches - l0, n * ((ne == 0) ? 1 : ne));
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ann_sample_sequencer.md
Name: ann_sample_sequencer

Overview:
- Upstream feeder for the ANN training/inference datapath.
- Holds a small on-chip set of training samples (input vector plus desired output) loaded over a valid/ready port.
- Replays the set for a programmed number of epochs: presents each sample, pulses ann_done to launch the network pass, and waits for ann_valid.
- In inference mode it captures the network output per sample and streams it out with its sample index.

Parameters:
- N_IN, 4, elements per input vector.
- N_OUT, 2, elements per desired/test output vector.
- DW, 16, bits per element (signed fixed point, opaque to this block).
- DEPTH, 16, sample slots; power of two.
- TIMEOUT, 4096, max cycles waiting for ann_valid before error.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-low reset.
- ld_valid  in  1  load sample handshake valid.
- ld_ready  out  1  high when IDLE and buffer not full.
- ld_input  in  N_IN*DW  input vector for the sample being loaded.
- ld_desired  in  N_OUT*DW  desired output for the sample being loaded.
- clear  in  1  empties the buffer; honoured only in IDLE.
- start  in  1  one-cycle pulse that begins a run; ignored unless IDLE.
- train_mode  in  1  sampled at start; 1 = train, 0 = inference.
- num_epochs  in  8  sampled at start; 0 is treated as 1.
- ann_input  out  N_IN*DW  to network input_vector.
- ann_desired  out  N_OUT*DW  to network desired_output.
- ann_train  out  1  to network train; latched train_mode during a run.
- ann_done  out  1  to network done; one-cycle launch pulse.
- ann_valid  in  1  from network valid; current sample finished.
- ann_test_output  in  N_OUT*DW  from network test_output.
- res_valid  out  1  one-cycle pulse, inference result available.
- res_data  out  N_OUT*DW  captured ann_test_output.
- res_index  out  $clog2(DEPTH)  sample index of res_data.
- busy  out  1  high in any state except IDLE.
- run_done  out  1  one-cycle pulse when a run completes or aborts.
- timeout_err  out  1  sticky; cleared by reset or the next accepted start.
- count  out  $clog2(DEPTH)+1  number of loaded samples.

Behaviour:
- Reset (RST=0 at an edge) applies from any state, including mid-run. Values after reset:
  - state=IDLE, count=0, write pointer=0.
  - ld_ready=1; busy=0.
  - ann_done=0, ann_train=0, ann_input=0, ann_desired=0.
  - res_valid=0, res_data=0, res_index=0.
  - run_done=0, timeout_err=0.
  - Buffer contents are not reset.
- Load:
  - A sample is written when ld_valid && ld_ready at the edge, to slot count; count then increments.
  - ld_ready = (state==IDLE) && (count<DEPTH). When full, ld_ready=0, the load is refused, and the buffer is unchanged.
  - If clear and ld_valid are both high in IDLE, clear wins: count=0 and no write.
- Start:
  - start in IDLE with count==0: no run; run_done pulses the next cycle.
  - Otherwise latch train_mode and num_epochs, set idx=0 and epoch=0, clear timeout_err, go to PRESENT.
- FSM:
  - IDLE: described above.
  - PRESENT (1 cycle): drive ann_input/ann_desired from slot idx (registered buffer read; outputs valid this cycle and held until the next PRESENT). Go to LAUNCH.
  - LAUNCH (1 cycle): ann_done=1, reset the timeout counter. Go to WAIT.
  - WAIT:
    - On ann_valid=1: if inference, capture res_data=ann_test_output and res_index=idx, and pulse res_valid on the next cycle. Go to NEXT.
    - If the timeout counter reaches TIMEOUT-1 without ann_valid: set timeout_err, go to FINISH.
    - ann_valid outside WAIT is ignored.
  - NEXT (1 cycle): if idx==count-1, set idx=0 and epoch++; if epoch+1==max(num_epochs,1), go to FINISH; else go to PRESENT. Otherwise idx++ and go to PRESENT.
  - FINISH (1 cycle): run_done=1, ann_train=0. Go to IDLE.
- Latency:
  - start to first ann_done pulse: 2 cycles.
  - ann_valid to the next ann_done: 3 cycles (NEXT, PRESENT, LAUNCH).
- ann_train holds the latched mode from PRESENT through WAIT for every sample in the run.
- start, clear and ld_valid are ignored while busy.

Decomposition:
- Package ann_seq_pkg holds:
  - the state enum (IDLE, PRESENT, LAUNCH, WAIT, NEXT, FINISH);
  - the N_IN/N_OUT/DW defaults;
  - the packed vector typedefs for input and output vectors.
- One sub-module, sample_buffer: a DEPTH x (N_IN+N_OUT)*DW single-write, registered-read memory.

Test Plan:
1. Load 3 samples, train_mode=1, num_epochs=2; the network model returns ann_valid 5 cycles after each ann_done.
   - 6 ann_done pulses, visiting idx 0,1,2,0,1,2.
   - ann_train=1 throughout; run_done pulses once; no res_valid.
2. Load 2 samples, train_mode=0, num_epochs=0; the model echoes test_output=0x0011_0022 then 0x0033_0044.
   - Two res_valid pulses with res_index 0 then 1 and matching res_data.
   - Exactly one epoch runs.
3. Load DEPTH=16 samples, then offer a 17th with ld_valid=1.
   - ld_ready=0 and count stays 16.
   - clear returns count to 0 and ld_ready to 1.
4. Run with the model never asserting ann_valid.
   - timeout_err=1 after 4096 WAIT cycles, run_done pulses, state returns to IDLE.
   - The next start clears timeout_err.
5. Assert RST=0 mid-WAIT during an epoch-1 run.
   - Next cycle: busy=0, ann_done=0, count=0.
   - A start pulse with count=0 yields only a run_done pulse.
6. Assert start and ld_valid while busy.
   - Both are ignored: count unchanged and no restart (idx sequence unaffected).
